// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped image I/O map.
// Used by io_deco and io_frame_reader.
package io_pkg;

  localparam int unsigned ADDR_W         = 22;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned PROC_BASE      = 120;
  localparam int unsigned ORIG_BASE      = 160120;
  localparam int unsigned SHOW_ADDR      = 116;
  localparam int unsigned SHOW_ORIG_ADDR = 100;

  typedef enum logic [0:0] {IDLE, RUN} frd_state_t;

  // Buffered pixel together with its end-of-frame tag.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } pix_entry_t;

endpackage

// File: rtl/io_frame_reader_if.sv
// Bundle of the frame reader's control, RAM read port and pixel stream signals.
// master = the frame reader, slave = the surrounding CPU/RAM/sink side.
interface io_frame_reader_if;
  import io_pkg::*;

  logic              cpu_we;
  logic              show_enb;
  logic              show_original_enb;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;
  logic              busy;
  logic              done;

  modport master (
    input  cpu_we, show_enb, show_original_enb, rd_data, pix_ready,
    output rd_en, rd_addr, pix_data, pix_valid, pix_last, busy, done
  );

  modport slave (
    output cpu_we, show_enb, show_original_enb, rd_data, pix_ready,
    input  rd_en, rd_addr, pix_data, pix_valid, pix_last, busy, done
  );

endinterface

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO holding returned pixels and their last tags; head is always visible.
module pix_skid_fifo
  import io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  pix_entry_t i_push_entry,
  input  logic       i_pop,
  output logic [1:0] o_count,
  output pix_entry_t o_head
);

  pix_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/io_frame_reader.sv
// Streams one image region from image RAM to the pixel sink after a CPU store
// to the show / show-original register.
module io_frame_reader
  import io_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 160000
) (
  input  logic             clk,
  input  logic             rst,
  io_frame_reader_if.master bus
);

  localparam int unsigned       CNT_W    = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  frd_state_t        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic              r_all_issued;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_busy;
  logic              r_done;

  logic              w_start;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_pop;
  logic              w_valid;
  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic [ADDR_W-1:0] w_addr;
  pix_entry_t        w_head;
  pix_entry_t        w_push_entry;

  assign w_start      = bus.cpu_we & (bus.show_enb | bus.show_original_enb);
  assign w_valid      = (w_count != 2'd0);
  assign w_pop        = w_valid & bus.pix_ready;
  assign w_addr       = r_base + ADDR_W'(r_issue_cnt);
  assign w_issue_last = (r_issue_cnt == LAST_IDX);

  // A read issued now lands next cycle; the pop of this cycle frees a slot in time.
  assign w_occ   = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = (r_state == RUN) & ~r_all_issued & (w_occ < 3'd2);

  assign w_push_entry = '{last: r_inflight_last, data: bus.rd_data};

  pix_skid_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (r_inflight),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_base          <= '0;
      r_addr_hold     <= '0;
      r_issue_cnt     <= '0;
      r_all_issued    <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_issue_last;
      r_done          <= 1'b0;
      if (w_issue) begin
        r_addr_hold <= w_addr;
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        if (w_issue_last) r_all_issued <= 1'b1;
      end
      if (r_state == IDLE) begin
        if (w_start) begin
          r_state      <= RUN;
          r_base       <= bus.show_original_enb ? ADDR_W'(ORIG_BASE) : ADDR_W'(PROC_BASE);
          r_issue_cnt  <= '0;
          r_all_issued <= 1'b0;
          r_busy       <= 1'b1;
        end
      end else if (w_pop && w_head.last) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = w_issue ? w_addr : r_addr_hold;
  assign bus.pix_data  = w_head.data;
  assign bus.pix_valid = w_valid;
  assign bus.pix_last  = w_valid & w_head.last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
